// File: rtl/usb_phy_pkg.sv
// Shared definitions for the USB PHY transmit/receive datapath.
//   tx_stuff_state_t : state encoding of the transmit bit stuffer
//   USB_STUFF_LEN    : run of consecutive 1s that forces a stuffed 0
//   USB_SYNC_BYTE    : SYNC pattern as sent LSB-first by the link layer
package usb_phy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } tx_stuff_state_t;

  localparam int unsigned USB_STUFF_LEN = 6;
  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

endpackage

// File: rtl/usb_tx_bit_stuffer.sv
// Transmit bit stuffer sitting in front of the NRZI encoder.
// Takes packet bytes over a valid/ready handshake and serialises them LSB-first,
// one bit per bit-time strobe, inserting a 0 after every STUFF_LEN consecutive 1s.
// After the final bit (and any trailing stuff bit) it pulses an EOP request.
//
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_bit_en      : bit-time strobe
//   i_data/i_last : byte and end-of-packet qualifier, accepted on i_valid && o_ready
//   o_ready       : hold register is free
//   o_bit         : NRZ bit to encoder, qualified by the o_bit_valid pulse
//   o_eop_req     : one-cycle pulse after the final bit of a packet
//   o_underrun    : one-cycle pulse when the next mid-packet byte was missing
//   o_busy        : packet in progress
module usb_tx_bit_stuffer
  import usb_phy_pkg::*;
#(
  parameter int unsigned STUFF_LEN = USB_STUFF_LEN
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_bit_en,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_bit,
  output logic       o_bit_valid,
  output logic       o_eop_req,
  output logic       o_underrun,
  output logic       o_busy
);

  localparam logic [3:0] StuffLen = 4'(STUFF_LEN);

  tx_stuff_state_t state_q, state_d;

  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_last_q, hold_last_d;
  logic       hold_full_q, hold_full_d;

  logic [7:0] shift_q, shift_d;
  logic       shift_last_q, shift_last_d;
  logic       shift_full_q, shift_full_d;
  logic [2:0] idx_q, idx_d;

  logic [3:0] ones_q, ones_d;

  logic bit_q, bit_d;
  logic bit_valid_q, bit_valid_d;
  logic eop_q, eop_d;
  logic underrun_q, underrun_d;

  logic accept;
  logic stuff_now;

  assign o_ready   = !hold_full_q;
  assign accept    = i_valid && !hold_full_q;
  assign stuff_now = (ones_q == StuffLen);

  always_comb begin
    logic [7:0] src;
    logic       src_last;
    logic [2:0] src_idx;
    logic       data_bit;
    logic       consume;

    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    shift_full_d = shift_full_q;
    idx_d        = idx_q;
    ones_d       = ones_q;
    bit_d        = 1'b0;
    bit_valid_d  = 1'b0;
    eop_d        = 1'b0;
    underrun_d   = 1'b0;
    src          = shift_q;
    src_last     = shift_last_q;
    src_idx      = idx_q;
    data_bit     = 1'b0;
    consume      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A byte parked in hold during FLUSH starts the next packet too.
        if (hold_full_q || accept) begin
          state_d = ACTIVE;
          ones_d  = 4'd0;
        end
      end

      ACTIVE: begin
        if (i_bit_en) begin
          if (stuff_now) begin
            // Stuff slot: bit index does not advance.
            bit_valid_d = 1'b1;
            ones_d      = 4'd0;
          end else if (shift_full_q || hold_full_q) begin
            // With the shift register empty, load from hold and emit its bit 0 now.
            if (!shift_full_q) begin
              src      = hold_data_q;
              src_last = hold_last_q;
              src_idx  = 3'd0;
              consume  = 1'b1;
            end
            data_bit    = src[src_idx];
            bit_d       = data_bit;
            bit_valid_d = 1'b1;
            if (data_bit) begin
              ones_d = (ones_q == 4'hF) ? ones_q : ones_q + 4'd1;
            end else begin
              ones_d = 4'd0;
            end
            if (src_idx == 3'd7) begin
              shift_full_d = 1'b0;
              idx_d        = 3'd0;
              if (src_last) begin
                state_d = FLUSH;
              end else if (hold_full_q) begin
                // Back-to-back: next byte moves in as bit 7 leaves.
                shift_d      = hold_data_q;
                shift_last_d = hold_last_q;
                shift_full_d = 1'b1;
                consume      = 1'b1;
              end
            end else begin
              shift_d      = src;
              shift_last_d = src_last;
              shift_full_d = 1'b1;
              idx_d        = src_idx + 3'd1;
            end
          end else begin
            underrun_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      FLUSH: begin
        if (i_bit_en) begin
          if (stuff_now) begin
            bit_valid_d = 1'b1;
            ones_d      = 4'd0;
          end else begin
            eop_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (consume) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_data_d = i_data;
      hold_last_d = i_last;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      hold_data_q  <= 8'h00;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_q      <= 8'h00;
      shift_last_q <= 1'b0;
      shift_full_q <= 1'b0;
      idx_q        <= 3'd0;
      ones_q       <= 4'd0;
      bit_q        <= 1'b0;
      bit_valid_q  <= 1'b0;
      eop_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      shift_full_q <= shift_full_d;
      idx_q        <= idx_d;
      ones_q       <= ones_d;
      bit_q        <= bit_d;
      bit_valid_q  <= bit_valid_d;
      eop_q        <= eop_d;
      underrun_q   <= underrun_d;
    end
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_eop_req   = eop_q;
  assign o_underrun  = underrun_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_bit_stuffer.sv
// Scoreboard bench for usb_tx_bit_stuffer: directed packets push hand-computed
// bit/EOP/underrun expectations; a monitor pops and compares on every output pulse.
module tb_usb_tx_bit_stuffer;
  import usb_phy_pkg::*;

  localparam int KBit = 0;
  localparam int KEop = 1;
  localparam int KUnd = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       last = 1'b0;
  logic       valid = 1'b0;
  logic       ready, nrz_bit, bit_valid, eop_req, underrun, busy;

  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_kind[$];
  logic exp_val[$];
  int   bits_seen = 0;
  int   strobe_div = 1;
  int   strobe_cnt = 0;

  always #5 clk = ~clk;

  usb_tx_bit_stuffer #(.STUFF_LEN(USB_STUFF_LEN)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_bit_en   (bit_en),
    .i_data     (data),
    .i_last     (last),
    .i_valid    (valid),
    .o_ready    (ready),
    .o_bit      (nrz_bit),
    .o_bit_valid(bit_valid),
    .o_eop_req  (eop_req),
    .o_underrun (underrun),
    .o_busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Strobe every strobe_div cycles, driven away from the active edge.
  always @(negedge clk) begin
    if (strobe_cnt >= strobe_div - 1) begin
      strobe_cnt = 0;
      bit_en = 1'b1;
    end else begin
      strobe_cnt++;
      bit_en = 1'b0;
    end
  end

  task automatic pop_cmp(input string name, input int kind, input logic val);
    int   k;
    logic v;
    if (exp_kind.size() == 0) begin
      n_checks++;
      $display("FAIL %s: unexpected output event, got kind %0d with scoreboard empty", name, kind);
    end else begin
      k = exp_kind.pop_front();
      v = exp_val.pop_front();
      check({name, "_kind"}, kind, k);
      if (kind == KBit) check({name, "_value"}, {31'd0, val}, {31'd0, v});
    end
  endtask

  // Monitor: sample shortly after the active edge.
  always @(posedge clk) begin
    #2;
    if (bit_valid) begin
      check("valid_on_strobe", {31'd0, bit_en}, 32'd1);
      check("busy_while_bit", {31'd0, busy}, 32'd1);
      bits_seen++;
      pop_cmp("bit", KBit, nrz_bit);
    end
    if (eop_req) pop_cmp("eop", KEop, 1'b0);
    if (underrun) pop_cmp("underrun", KUnd, 1'b0);
  end

  // Push n bits written left-to-right in emission order.
  task automatic push_seq(input int n, input logic [63:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      exp_kind.push_back(KBit);
      exp_val.push_back(v[i]);
    end
  endtask

  task automatic push_evt(input int kind);
    exp_kind.push_back(kind);
    exp_val.push_back(1'b0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    data  = d;
    last  = l;
    valid = 1'b1;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", {31'd0, ready}, 32'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_kind.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_kind.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_bit"}, {31'd0, nrz_bit}, 32'd0);
    check({name, "_bit_valid"}, {31'd0, bit_valid}, 32'd0);
    check({name, "_eop"}, {31'd0, eop_req}, 32'd0);
    check({name, "_underrun"}, {31'd0, underrun}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int n;
    int target;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: single SYNC-like byte 0x80
    strobe_div = 1;
    push_seq(8, 8'b00000001);
    push_evt(KEop);
    send_byte(8'h80, 1'b1);
    wait_drain("t1", 200);

    // 2: 0xFF, 0x00 back-to-back; stuff after six 1s
    push_seq(17, 17'b1111110_11_00000000);
    push_evt(KEop);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b1);
    wait_drain("t2", 200);

    // 3: 0x00, 0xFC; trailing stuff bit before EOP
    push_seq(17, 17'b00000000_00111111_0);
    push_evt(KEop);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFC, 1'b1);
    wait_drain("t3", 200);

    // 4: strobe every 4th cycle, 0xA5
    strobe_div = 4;
    push_seq(8, 8'b10100101);
    push_evt(KEop);
    send_byte(8'hA5, 1'b1);
    wait_drain("t4", 400);
    strobe_div = 1;
    repeat (4) @(negedge clk);

    // 5: underrun after a non-last byte
    push_seq(8, 8'b00000001);
    push_evt(KUnd);
    send_byte(8'h80, 1'b0);
    wait_drain("t5", 200);
    check("t5_busy_after_underrun", {31'd0, busy}, 32'd0);
    check("t5_ready_after_underrun", {31'd0, ready}, 32'd1);
    repeat (6) @(negedge clk);

    // 6: reset mid-packet, then a fresh 0xFF starts with a clean ones count
    push_seq(3, 3'b111);
    target = bits_seen + 3;
    send_byte(8'hFF, 1'b1);
    n = 0;
    while (bits_seen < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_three_bits", bits_seen, target);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_reset");
    check("t6_sb_empty", exp_kind.size(), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push_seq(9, 9'b111111_0_11);
    push_evt(KEop);
    send_byte(8'hFF, 1'b1);
    wait_drain("t6", 200);

    check("final_sb_empty", exp_kind.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
